// File: rtl/pipelined_multiplier.sv
// rtl/pipelined_multiplier.sv - STAGES-deep valid/ready multiplier with signed select and tag pass-through.
// Optional multiply-accumulate mode: define MUL_ACC_EN.
module pipelined_multiplier #(
   parameter int A_W    = 8,
   parameter int B_W    = 8,
   parameter int TAG_W  = 4,
   parameter int STAGES = 3,
   parameter int ACC_W  = 32,
   localparam int P_W   = A_W + B_W,
`ifdef MUL_ACC_EN
   localparam int OUT_W = ACC_W
`else
   localparam int OUT_W = P_W
`endif
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic             in_signed,
   input  logic [TAG_W-1:0] in_tag,
`ifdef MUL_ACC_EN
   input  logic             in_clr,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy
);

   if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
      $error("STAGES must be in 1..8");
   end
   if (ACC_W < P_W) begin : g_bad_acc
      $error("ACC_W must be >= A_W+B_W");
   end

   logic             rdy_q;
   logic             out_v_q;
   logic [OUT_W-1:0] data_q;
   logic [TAG_W-1:0] tag_q;
   logic             stall, adv, accept;
   logic [P_W-1:0]   a_ext, b_ext, prod_in;

   logic [STAGES-1:0] v_q;
   logic [P_W-1:0]    prod_q [STAGES];
   logic [TAG_W-1:0]  t_q    [STAGES];
`ifdef MUL_ACC_EN
   logic [STAGES-1:0] sgn_q, clr_q;
   logic [ACC_W-1:0]  acc_q, res;
`endif

   // The whole pipeline freezes only when a finished result is waiting on the consumer.
   assign in_ready = rdy_q & ~stall;

   always_comb begin
      stall   = out_v_q & ~out_ready;
      adv     = ~stall;
      accept  = in_valid & in_ready;
      a_ext   = {{B_W{in_signed & in_a[A_W-1]}}, in_a};
      b_ext   = {{A_W{in_signed & in_b[B_W-1]}}, in_b};
      prod_in = a_ext * b_ext;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            prod_q[i] <= '0;
            t_q[i]    <= '0;
         end
`ifdef MUL_ACC_EN
         sgn_q <= '0;
         clr_q <= '0;
`endif
      end else if (adv) begin
         v_q[0]    <= accept;
         prod_q[0] <= prod_in;
         t_q[0]    <= in_tag;
`ifdef MUL_ACC_EN
         sgn_q[0]  <= in_signed;
         clr_q[0]  <= in_clr;
`endif
         for (int i = 1; i < STAGES; i++) begin
            v_q[i]    <= v_q[i-1];
            prod_q[i] <= prod_q[i-1];
            t_q[i]    <= t_q[i-1];
`ifdef MUL_ACC_EN
            sgn_q[i]  <= sgn_q[i-1];
            clr_q[i]  <= clr_q[i-1];
`endif
         end
      end
   end

`ifdef MUL_ACC_EN
   always_comb begin
      res = (clr_q[STAGES-1] ? '0 : acc_q)
          + {{(ACC_W-P_W){sgn_q[STAGES-1] & prod_q[STAGES-1][P_W-1]}}, prod_q[STAGES-1]};
   end
`endif

   // Output register; data/tag only load with a real beat so a bubble leaves them untouched.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdy_q   <= 1'b0;
         out_v_q <= 1'b0;
         data_q  <= '0;
         tag_q   <= '0;
`ifdef MUL_ACC_EN
         acc_q   <= '0;
`endif
      end else begin
         rdy_q <= 1'b1;
         if (adv) begin
            out_v_q <= v_q[STAGES-1];
            if (v_q[STAGES-1]) begin
               tag_q  <= t_q[STAGES-1];
`ifdef MUL_ACC_EN
               data_q <= res;
               acc_q  <= res;
`else
               data_q <= prod_q[STAGES-1];
`endif
            end
         end
      end
   end

   assign out_valid = out_v_q;
   assign out_data  = data_q;
   assign out_tag   = tag_q;
   assign busy      = out_v_q | (|v_q);

endmodule

// File: tb/tb_pipelined_multiplier.sv
// tb/tb_pipelined_multiplier.sv - randomized self-checking bench for pipelined_multiplier.
module tb_pipelined_multiplier;
   localparam int STAGES = 3;
`ifdef MUL_ACC_EN
   localparam int OW = 32;
`else
   localparam int OW = 16;
`endif

   logic clk = 1'b0, reset_n = 1'b0;
   logic in_valid = 1'b0, in_signed = 1'b0, in_clr = 1'b0, out_ready = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic [3:0] in_tag = '0;
   logic in_ready, out_valid, busy;
   logic [OW-1:0] out_data;
   logic [3:0] out_tag;

   pipelined_multiplier #(.STAGES(STAGES)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
`ifdef MUL_ACC_EN
      .in_clr(in_clr),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_tag(out_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0, n_bad = 0;
   logic s_ir, s_ov, s_bz;
   logic [OW-1:0] s_od;
   logic [3:0] s_ot;
   int s_cyc;

   logic [OW-1:0] exp_d[$];
   logic [3:0]    exp_t[$];
   int            exp_c[$];
   logic [OW-1:0] acc_m = '0;

   // Mathematical product of the operands as integers, truncated to the output width.
   function automatic logic [OW-1:0] ref_prod(input logic [7:0] a, input logic [7:0] b, input logic s);
      longint x, y, p;
      x = s ? longint'($signed(a)) : longint'(a);
      y = s ? longint'($signed(b)) : longint'(b);
      p = x * y;
      return OW'(p);
   endfunction

   task automatic tick(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic c, input logic ordy);
      logic [OW-1:0] e;
      in_valid = v; in_a = a; in_b = b; in_signed = s; in_tag = t; in_clr = c; out_ready = ordy;
      #1;
      s_ir = in_ready; s_ov = out_valid; s_od = out_data; s_ot = out_tag; s_bz = busy; s_cyc = cyc;
      if (v && in_ready) begin
`ifdef MUL_ACC_EN
         e = (c ? '0 : acc_m) + ref_prod(a, b, s);
         acc_m = e;
`else
         e = ref_prod(a, b, s);
`endif
         exp_d.push_back(e); exp_t.push_back(t); exp_c.push_back(cyc + 1);
      end
      @(negedge clk);
   endtask

   task automatic pop_exp(output logic [OW-1:0] d, output logic [3:0] t, output int c, output bit ok);
      ok = exp_d.size() != 0; d = '0; t = '0; c = 0;
      if (ok) begin
         d = exp_d.pop_front(); t = exp_t.pop_front(); c = exp_c.pop_front();
      end
   endtask

   task automatic test_reset();
      bit seen = 0;
      reset_n = 1'b0;
      @(negedge clk);
      tick(0, 0, 0, 0, 0, 0, 1);
      n_cmp++; if (s_ir !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready: got %b want 0", s_ir); end
      n_cmp++; if (s_ov !== 1'b0 || s_bz !== 1'b0 || s_od !== '0 || s_ot !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got v=%b busy=%b d=%0h t=%0h want all 0", s_ov, s_bz, s_od, s_ot);
      end
      reset_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_clock: got %b want 0", in_ready); end
      @(negedge clk);
      tick(1, 8'($urandom), 8'($urandom), 1'($urandom), 4'd1, 0, 1);
      n_cmp++; if (s_ir !== 1'b1) begin n_bad++; $display("FAIL ready_after_release: got %b want 1", s_ir); end
      tick(1, 8'($urandom), 8'($urandom), 1'($urandom), 4'd2, 0, 1);
      tick(0, 0, 0, 0, 0, 0, 1);
      #2;
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_in_flight: got %b want 1", busy); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: got v=%b busy=%b rdy=%b want 0 0 0", out_valid, busy, in_ready);
      end
      exp_d.delete(); exp_t.delete(); exp_c.delete(); acc_m = '0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 0; k < STAGES + 5; k++) begin
         tick(0, 0, 0, 0, 0, 0, 1);
         seen |= s_ov;
      end
      n_cmp++; if (seen) begin n_bad++; $display("FAIL no_result_after_reset: got out_valid=1 want none"); end
   endtask

   task automatic test_directed();
      logic [7:0] ta[4] = '{8'd4, 8'd255, 8'hFC, 8'hFC};
      logic [7:0] tb_[4] = '{8'd10, 8'd255, 8'h0A, 8'h0A};
      logic       ts[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifndef MUL_ACC_EN
      logic [15:0] tc[4] = '{16'd40, 16'd65025, 16'hFFD8, 16'd2520};
`endif
      logic [OW-1:0] ed; logic [3:0] et; int ec; bit ok; int r = 0;
      for (int k = 0; k < 12; k++) begin
         if (k < 4) tick(1, ta[k], tb_[k], ts[k], 4'(k + 1), 0, 1);
         else       tick(0, 0, 0, 0, 0, 0, 1);
         if (s_ov) begin
            pop_exp(ed, et, ec, ok);
            n_cmp++; if (!ok || s_od !== ed || s_ot !== et) begin
               n_bad++; $display("FAIL directed_data[%0d]: got %0h/%0h want %0h/%0h", r, s_od, s_ot, ed, et);
            end
            n_cmp++; if (s_cyc - ec != STAGES) begin
               n_bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", r, s_cyc - ec, STAGES);
            end
`ifndef MUL_ACC_EN
            if (r < 4) begin
               n_cmp++; if (s_od !== tc[r]) begin
                  n_bad++; $display("FAIL directed_const[%0d]: got %0h want %0h", r, s_od, tc[r]);
               end
            end
`endif
            r++;
         end
      end
      n_cmp++; if (r != 4) begin n_bad++; $display("FAIL directed_count: got %0d want 4", r); end
   endtask

   task automatic test_backpressure();
      int sent = 0, got = 0; bit prev_stall = 0; logic ordy;
      logic [OW-1:0] pd = '0, ed; logic [3:0] pt = '0, et; int ec; bit ok;
      for (int k = 0; k < 60 && got < 6; k++) begin
         ordy = !(k >= 4 && k < 8);
         tick(sent < 6, 8'($urandom), 8'($urandom), 1'($urandom), 4'(sent), 1'($urandom), ordy);
         if (sent < 6 && s_ir) sent++;
         if (s_ov && !ordy) begin
            n_cmp++; if (s_ir !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", s_ir); end
            if (prev_stall) begin
               n_cmp++; if (s_od !== pd || s_ot !== pt) begin
                  n_bad++; $display("FAIL bp_stable: got %0h/%0h want %0h/%0h", s_od, s_ot, pd, pt);
               end
            end
         end
         prev_stall = s_ov && !ordy; pd = s_od; pt = s_ot;
         if (s_ov && ordy) begin
            pop_exp(ed, et, ec, ok);
            n_cmp++; if (!ok || s_od !== ed || s_ot !== et || s_ot !== 4'(got)) begin
               n_bad++; $display("FAIL bp_order[%0d]: got %0h/%0h want %0h/%0h", got, s_od, s_ot, ed, et);
            end
            got++;
         end
      end
      n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", got); end
   endtask

   task automatic test_back_to_back();
      int got = 0, first = -1, last = -1; bit checked = 0;
      logic [OW-1:0] ed; logic [3:0] et; int ec; bit ok;
      for (int k = 0; k < 30; k++) begin
         tick(k < 16, 8'($urandom), 8'($urandom), 1'($urandom), 4'(k), 1'($urandom), 1);
         if (s_ov) begin
            pop_exp(ed, et, ec, ok);
            n_cmp++; if (!ok || s_od !== ed || s_ot !== et || s_cyc - ec != STAGES) begin
               n_bad++; $display("FAIL b2b_data[%0d]: got %0h/%0h lat %0d want %0h/%0h lat %0d",
                                 got, s_od, s_ot, s_cyc - ec, ed, et, STAGES);
            end
            if (first < 0) first = s_cyc;
            last = s_cyc; got++;
         end else if (got == 16 && !checked) begin
            checked = 1;
            n_cmp++; if (s_bz !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_drop: got %b want 0", s_bz); end
         end
      end
      n_cmp++; if (got != 16 || last - first != 15 || !checked) begin
         n_bad++; $display("FAIL b2b_throughput: got %0d results over %0d cycles want 16 over 15", got, last - first);
      end
   endtask

   task automatic test_random();
      logic ordy; int got = 0;
      logic [OW-1:0] ed; logic [3:0] et; int ec; bit ok;
      for (int k = 0; k < 120; k++) begin
         ordy = (k >= 100) || ($urandom_range(0, 9) < 7);
         tick((k < 100) && ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom), 1'($urandom),
              4'($urandom), ($urandom_range(0, 4) == 0), ordy);
         if (s_ov && ordy) begin
            pop_exp(ed, et, ec, ok);
            n_cmp++; if (!ok || s_od !== ed || s_ot !== et) begin
               n_bad++; $display("FAIL random_data[%0d]: got %0h/%0h want %0h/%0h", got, s_od, s_ot, ed, et);
            end
            got++;
         end
      end
      n_cmp++; if (exp_d.size() != 0 || s_bz !== 1'b0) begin
         n_bad++; $display("FAIL random_drain: got %0d pending busy=%b want 0 0", exp_d.size(), s_bz);
      end
   endtask

`ifdef MUL_ACC_EN
   task automatic test_accumulate();
      logic [7:0]  ta[4] = '{8'd2, 8'd4, 8'd1, 8'd7};
      logic [7:0]  tb_[4] = '{8'd3, 8'd5, 8'd1, 8'd7};
      logic        tcl[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] tv[4] = '{32'd6, 32'd26, 32'd27, 32'd49};
      logic [OW-1:0] ed; logic [3:0] et; int ec; bit ok; int r = 0;
      for (int k = 0; k < 10; k++) begin
         if (k < 4) tick(1, ta[k], tb_[k], 1'b0, 4'(k), tcl[k], 1);
         else       tick(0, 0, 0, 0, 0, 0, 1);
         if (s_ov) begin
            pop_exp(ed, et, ec, ok);
            n_cmp++; if (!ok || s_od !== ed || (r < 4 && s_od !== tv[r])) begin
               n_bad++; $display("FAIL acc_data[%0d]: got %0d want %0d", r, s_od, ed);
            end
            r++;
         end
      end
      n_cmp++; if (r != 4) begin n_bad++; $display("FAIL acc_count: got %0d want 4", r); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_back_to_back();
      test_random();
`ifdef MUL_ACC_EN
      test_accumulate();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
